// File: rtl/alu_seq.sv
// alu_seq: registered ALU between the execute-stage operand muxes and the
// writeback register. Uses the same 4-bit command encoding and {Z,C,N,V}
// status ordering as the combinational datapath ALU.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   in_valid         operation presented on alu_in1/alu_in2/alu_command/s_bit
//   in_ready         operation accepted when in_valid & in_ready at clk edge
//   alu_in1/alu_in2  operands (alu_in2 low log2(WIDTH) bits = shift amount)
//   alu_command      operation select
//   s_bit            1 = write this op's flags into status_register
//   out_valid        alu_out holds an unconsumed result
//   out_ready        consumer takes the result when out_valid & out_ready
//   alu_out          registered result
//   status_register  registered flags {Z,C,N,V}
//   busy             iterative multiplier running
//
// Handshake: a transfer happens on an input or output channel exactly at a
// rising clk edge where both valid and ready are 1; valid must be held by
// the sender until that edge and is never queued while ready is 0.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [3:0]       alu_command,
    input  logic             s_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       status_register,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] CMD_NOP0 = 4'b0000;
    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;
    localparam logic [3:0] CMD_LSL  = 4'b1010;
    localparam logic [3:0] CMD_LSR  = 4'b1011;
    localparam logic [3:0] CMD_ASR  = 4'b1100;
    localparam logic [3:0] CMD_ROR  = 4'b1101;
    localparam logic [3:0] CMD_MUL  = 4'b1110;
    localparam logic [3:0] CMD_NOP1 = 4'b1111;

    // Output / status registers
    logic [WIDTH-1:0] r_alu_out;
    logic             r_out_valid;
    logic [3:0]       r_status;

    // Multiplier state
    logic             r_busy;
    logic [WIDTH-1:0] r_mul_a;     // multiplicand, shifts left each step
    logic [WIDTH-1:0] r_mul_b;     // multiplier, shifts right each step
    logic [WIDTH-1:0] r_mul_acc;
    logic [SW-1:0]    r_mul_cnt;
    logic             r_mul_s;     // s_bit captured at acceptance

    logic             w_accept;
    logic             w_is_mul;
    logic             w_flag_upd;
    logic             w_c_in;
    logic [SW-1:0]    w_amt;
    logic [SW:0]      w_ror_sh;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic signed [WIDTH:0] w_asr;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_mul_step;
    logic             w_mul_last;
    logic [3:0]       w_mul_flags;

    assign in_ready = !r_busy && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_is_mul   = MUL_ENABLE && (alu_command == CMD_MUL);
    // NOPs (and MUL when the multiplier is not built) never touch the flags.
    assign w_flag_upd = (alu_command != CMD_NOP0) && (alu_command != CMD_NOP1) &&
                        (alu_command != CMD_MUL);

    assign w_c_in = r_status[2];
    assign w_amt  = alu_in2[SW-1:0];

    // Adder and subtractor carry chains; subtraction is in1 + ~in2 + cin so
    // the carry out is directly NOT borrow.
    assign w_add = {1'b0, alu_in1} + {1'b0, alu_in2} +
                   {{WIDTH{1'b0}}, (alu_command == CMD_ADC) && w_c_in};
    assign w_sub = {1'b0, alu_in1} + {1'b0, ~alu_in2} +
                   {{WIDTH{1'b0}}, (alu_command == CMD_SBC) ? w_c_in : 1'b1};

    // Shifts carry one extra bit so the last bit shifted out lands in it;
    // with amount 0 that extra bit stays 0.
    assign w_lsl    = {1'b0, alu_in1} << w_amt;
    assign w_lsr    = {alu_in1, 1'b0} >> w_amt;
    assign w_asr    = $signed({alu_in1, 1'b0}) >>> w_amt;
    assign w_ror_sh = (SW+1)'(WIDTH) - {1'b0, w_amt};
    // Amount 0 gives a left shift by WIDTH, which yields 0, so w_ror = in1.
    assign w_ror    = (alu_in1 >> w_amt) | (alu_in1 << w_ror_sh);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_command)
            CMD_MOV: w_res = alu_in2;
            CMD_MVN: w_res = ~alu_in2;
            CMD_ADD, CMD_ADC: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                        (w_res[WIDTH-1] != alu_in1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                        (w_res[WIDTH-1] != alu_in1[WIDTH-1]);
            end
            CMD_AND: w_res = alu_in1 & alu_in2;
            CMD_ORR: w_res = alu_in1 | alu_in2;
            CMD_EOR: w_res = alu_in1 ^ alu_in2;
            CMD_LSL: begin
                w_res = w_lsl[WIDTH-1:0];
                w_c   = w_lsl[WIDTH];
            end
            CMD_LSR: begin
                w_res = w_lsr[WIDTH:1];
                w_c   = w_lsr[0];
            end
            CMD_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            CMD_ROR: begin
                w_res = w_ror;
                // The last bit rotated out reappears as the new msb.
                w_c   = (w_amt != '0) && w_ror[WIDTH-1];
            end
            default: w_res = '0;
        endcase
    end

    assign w_flags = {(w_res == '0), w_c, w_res[WIDTH-1], w_v};

    // Final multiplier step is folded into the load so the result appears
    // exactly WIDTH edges after acceptance.
    assign w_mul_step  = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
    assign w_mul_last  = (r_mul_cnt == SW'(WIDTH - 1));
    assign w_mul_flags = {(w_mul_step == '0), 1'b0, w_mul_step[WIDTH-1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out   <= '0;
            r_out_valid <= 1'b0;
            r_status    <= '0;
            r_busy      <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_acc   <= '0;
            r_mul_cnt   <= '0;
            r_mul_s     <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            // Any previous result is consumed at this edge (in_ready implies it).
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_mul_a     <= alu_in1;
            r_mul_b     <= alu_in2;
            r_mul_acc   <= '0;
            r_mul_cnt   <= '0;
            r_mul_s     <= s_bit;
        end else if (w_accept) begin
            r_alu_out   <= w_res;
            r_out_valid <= 1'b1;
            if (s_bit && w_flag_upd) begin
                r_status <= w_flags;
            end
        end else if (r_busy) begin
            r_mul_a   <= r_mul_a << 1;
            r_mul_b   <= r_mul_b >> 1;
            r_mul_acc <= w_mul_step;
            r_mul_cnt <= r_mul_cnt + SW'(1);
            if (w_mul_last) begin
                r_busy      <= 1'b0;
                r_alu_out   <= w_mul_step;
                r_out_valid <= 1'b1;
                if (r_mul_s) begin
                    r_status <= w_mul_flags;
                end
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign alu_out         = r_alu_out;
    assign out_valid       = r_out_valid;
    assign status_register = r_status;
    assign busy            = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32, MUL_ENABLE=1).
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] MOV = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] ADC = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100;
    localparam logic [3:0] SBC = 4'b0101;
    localparam logic [3:0] AND = 4'b0110;
    localparam logic [3:0] ORR = 4'b0111;
    localparam logic [3:0] EOR = 4'b1000;
    localparam logic [3:0] MVN = 4'b1001;
    localparam logic [3:0] LSL = 4'b1010;
    localparam logic [3:0] LSR = 4'b1011;
    localparam logic [3:0] ASR = 4'b1100;
    localparam logic [3:0] ROR = 4'b1101;
    localparam logic [3:0] MUL = 4'b1110;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [3:0]   alu_command;
    logic         s_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic [3:0]   status_register;
    logic         busy;

    int checks;
    int errors;

    alu_seq #(.WIDTH(W), .MUL_ENABLE(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .alu_command     (alu_command),
        .s_bit           (s_bit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_out         (alu_out),
        .status_register (status_register),
        .busy            (busy)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one single-cycle op at a negedge, let it be accepted at the next
    // posedge, then check the registered result 1 ns later.
    task automatic do_op(input string tag, input logic [3:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_st);
        @(negedge clk);
        alu_command = cmd;
        alu_in1     = a;
        alu_in2     = b;
        s_bit       = s;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, W'(out_valid), W'(1));
        chk({tag, "_alu_out"}, alu_out, exp_res);
        chk({tag, "_status"}, W'(status_register), W'(exp_st));
    endtask

    initial begin
        logic mul_ok;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_command = NOP;
        s_bit       = 1'b0;

        // Reset
        #3 rst_n = 1'b0;
        #1;
        chk("rst_alu_out", alu_out, '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_status", W'(status_register), '0);
        chk("rst_busy", W'(busy), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle ops; flags {Z,C,N,V}
        do_op("add_ovf",  ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b0011);
        do_op("add_carry",ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b1100);
        do_op("adc_s0",   ADC, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0001, 4'b1100);
        do_op("sub_neg",  SUB, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0010);
        do_op("lsr_1",    LSR, 32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0001, 4'b0100);
        do_op("mov",      MOV, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'b0000);
        do_op("mvn",      MVN, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0010);
        do_op("and",      AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 4'b1000);
        do_op("orr_s0",   ORR, 32'hF000_0000, 32'h0000_000F, 1'b0, 32'hF000_000F, 4'b1000);
        do_op("eor",      EOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1, 32'h5A5A_5A5A, 4'b0000);
        do_op("lsl_1",    LSL, 32'h8000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 4'b0100);
        do_op("asr_4",    ASR, 32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000, 4'b0010);
        do_op("ror_1",    ROR, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b0110);
        // amount field (low 5 bits) is 0 -> result = in1, C = 0
        do_op("lsl_amt0", LSL, 32'h8000_0000, 32'h0000_0020, 1'b1, 32'h8000_0000, 4'b0010);
        do_op("ror_amt0", ROR, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0001, 4'b0000);
        do_op("nop_s1",   NOP, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0000_0000, 4'b0000);
        do_op("nop15_s1", 4'b1111, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 4'b0000);
        // C=0 here, so SBC subtracts an extra 1: 10-3-1=6, no borrow -> C=1
        do_op("sbc_c0",   SBC, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0006, 4'b0100);
        do_op("adc_c1",   ADC, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 4'b0000);
        do_op("sub_zero", SUB, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1100);

        // Result consumed on an idle edge
        @(posedge clk);
        #1;
        chk("consumed_out_valid", W'(out_valid), '0);

        // Backpressure: first result held while out_ready=0
        do_op("bp_first", ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b0011);
        @(negedge clk);
        out_ready   = 1'b0;
        alu_command = ADD;
        alu_in1     = 32'h0000_0005;
        alu_in2     = 32'h0000_0006;
        s_bit       = 1'b1;
        in_valid    = 1'b1;
        #1;
        chk("bp_in_ready_low", W'(in_ready), '0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_out", alu_out, 32'h8000_0000);
        chk("bp_hold_valid", W'(out_valid), W'(1));
        chk("bp_hold_status", W'(status_register), W'(4'b0011));
        chk("bp_in_ready_still_low", W'(in_ready), '0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_out", alu_out, 32'h0000_000B);
        chk("bp_second_valid", W'(out_valid), W'(1));
        chk("bp_second_status", W'(status_register), W'(4'b0000));

        // Leave status non-zero so the MUL flag write is visible
        do_op("sub_v", SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0101);

        // MUL: accepted at edge 0, result at edge 32, in_valid held throughout
        @(negedge clk);
        alu_command = MUL;
        alu_in1     = 32'h0001_0001;
        alu_in2     = 32'h0001_0001;
        s_bit       = 1'b1;
        in_valid    = 1'b1;
        chk("mul_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        chk("mul_busy_start", W'(busy), W'(1));
        chk("mul_in_ready_low", W'(in_ready), '0);
        chk("mul_out_valid_low", W'(out_valid), '0);
        mul_ok = 1'b1;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) mul_ok = 1'b0;
        end
        chk("mul_busy_window", W'(mul_ok), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mul_out_valid", W'(out_valid), W'(1));
        chk("mul_result", alu_out, 32'h0002_0001);
        chk("mul_busy_end", W'(busy), '0);
        chk("mul_status", W'(status_register), W'(4'b0000));
        @(posedge clk);
        #1;
        chk("mul_no_reaccept", W'(busy), '0);

        // Reset in the middle of a MUL
        do_op("pre_rst", SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0101);
        @(negedge clk);
        alu_command = MUL;
        alu_in1     = 32'h0000_0003;
        alu_in2     = 32'h0000_0005;
        s_bit       = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("rst_mid_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_alu_out", alu_out, '0);
        chk("rst_mid_out_valid", W'(out_valid), '0);
        chk("rst_mid_status", W'(status_register), '0);
        chk("rst_mid_busy", W'(busy), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_out_valid", W'(out_valid), '0);
        chk("post_rst_busy", W'(busy), '0);
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        chk("post_rst_alu_out", alu_out, '0);
        do_op("post_rst_add", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
